// File: rtl/sw_debounce_pkg.sv
// Shared constants and types for the slide-switch debouncer.
package sw_debounce_pkg;

    localparam int N_SW_DEFAULT   = 4;
    localparam int DEBOUNCE_SIM   = 16;
    localparam int DEBOUNCE_BOARD = 1_000_000;  // 20 ms at 50 MHz

    typedef logic [N_SW_DEFAULT-1:0] sw_vec_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch line: 2-flop synchroniser, restart-on-bounce counter,
// stable bit and registered rise/fall strobes.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall,
    output logic o_flip
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_pipe;  // [0] = first flop, [1] = synchronised value
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          flip;

    assign sync2 = sync_pipe[1];
    // Stable value is about to take the synchronised value on this edge.
    assign flip  = (sync2 != stable) && (cnt == CNT_MAX);

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_pipe <= '0;
        else          sync_pipe <= {sync_pipe[0], i_sw};
    end

    // Count consecutive differing cycles; any agreement restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Edge strobes registered on the same edge the stable bit changes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            o_rise <= flip &  sync2;
            o_fall <= flip & ~sync2;
        end
    end

    assign o_stable = stable;
    assign o_flip   = flip;

endmodule

// File: rtl/sw_debounce.sv
// Debounces N_SW slide-switch lines for the LED pattern FSM.
// Optional SW_DEBOUNCE_ONEHOT_EN: o_sw passes through a register that keeps
// at most one bit set (first switch wins), adding one cycle on o_sw only.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int N_SW            = N_SW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_SW-1:0] i_sw,
    output logic [N_SW-1:0] o_sw,
    output logic [N_SW-1:0] o_rise,
    output logic [N_SW-1:0] o_fall,
    output logic            o_changed
);

    logic [N_SW-1:0] stable_vec;
    logic [N_SW-1:0] flip_vec;

    for (genvar g = 0; g < N_SW; g++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_sw    (i_sw[g]),
            .o_stable(stable_vec[g]),
            .o_rise  (o_rise[g]),
            .o_fall  (o_fall[g]),
            .o_flip  (flip_vec[g])
        );
    end

    // Any-bit change strobe, aligned with the per-bit strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_changed <= 1'b0;
        else          o_changed <= |flip_vec;
    end

`ifdef SW_DEBOUNCE_ONEHOT_EN
    logic [N_SW-1:0] sw_q;

    // Keep at most one bit hot; a multi-bit vector holds the last legal value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            sw_q <= '0;
        else if (stable_vec == '0)
            sw_q <= '0;
        else if ((stable_vec & (stable_vec - 1'b1)) == '0)
            sw_q <= stable_vec;
    end

    assign o_sw = sw_q;
`else
    assign o_sw = stable_vec;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

`ifdef SW_DEBOUNCE_ONEHOT_EN
    localparam int OSW_LAT = 1;
`else
    localparam int OSW_LAT = 0;
`endif

    logic    i_clk;
    logic    i_rst_n;
    sw_vec_t i_sw;
    sw_vec_t o_sw, o_rise, o_fall;
    logic    o_changed;

    int checks   = 0;
    int failures = 0;

    sw_debounce #(.N_SW(4), .DEBOUNCE_CYCLES(4)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_sw     (i_sw),
        .o_sw     (o_sw),
        .o_rise   (o_rise),
        .o_fall   (o_fall),
        .o_changed(o_changed)
    );

    initial i_clk = 1'b0;
    always #10 i_clk = ~i_clk;

    // Advance n edges, landing 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic test_reset;
        i_sw = 4'b1111;
        tick(3);
        checks++; if (o_sw !== 4'b0000) begin failures++; $display("FAIL rst_osw got=%b exp=0000", o_sw); end
        checks++; if (o_rise !== 4'b0000) begin failures++; $display("FAIL rst_rise got=%b exp=0000", o_rise); end
        checks++; if (o_fall !== 4'b0000) begin failures++; $display("FAIL rst_fall got=%b exp=0000", o_fall); end
        checks++; if (o_changed !== 1'b0) begin failures++; $display("FAIL rst_changed got=%b exp=0", o_changed); end
        i_sw = 4'b0001;
        i_rst_n = 1'b1;
        tick(10);
        checks++; if (o_sw !== 4'b0001) begin failures++; $display("FAIL rst_preset_osw got=%b exp=0001", o_sw); end
        // Assert reset between edges: outputs must clear without a clock.
        #5 i_rst_n = 1'b0;
        #1;
        checks++; if (o_sw !== 4'b0000) begin failures++; $display("FAIL rst_async_osw got=%b exp=0000", o_sw); end
        tick(1);
        i_sw = 4'b0000;
        i_rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_accept;
        i_sw = 4'b0001;
        tick(5);
        checks++; if (o_sw !== 4'b0000) begin failures++; $display("FAIL acc_early_osw got=%b exp=0000", o_sw); end
        checks++; if (o_rise !== 4'b0000) begin failures++; $display("FAIL acc_early_rise got=%b exp=0000", o_rise); end
        tick(1);
        checks++; if (o_rise !== 4'b0001) begin failures++; $display("FAIL acc_rise got=%b exp=0001", o_rise); end
        checks++; if (o_changed !== 1'b1) begin failures++; $display("FAIL acc_changed got=%b exp=1", o_changed); end
        checks++; if (o_fall !== 4'b0000) begin failures++; $display("FAIL acc_fall0 got=%b exp=0000", o_fall); end
        tick(OSW_LAT);
        checks++; if (o_sw !== 4'b0001) begin failures++; $display("FAIL acc_osw got=%b exp=0001", o_sw); end
        tick(1);
        checks++; if (o_rise !== 4'b0000 || o_changed !== 1'b0) begin failures++; $display("FAIL acc_strobe_len rise=%b chg=%b exp=0000/0", o_rise, o_changed); end
        tick(2);
        i_sw = 4'b0000;
        tick(5);
        checks++; if (o_fall !== 4'b0000) begin failures++; $display("FAIL acc_early_fall got=%b exp=0000", o_fall); end
        tick(1);
        checks++; if (o_fall !== 4'b0001 || o_changed !== 1'b1) begin failures++; $display("FAIL acc_fall fall=%b chg=%b exp=0001/1", o_fall, o_changed); end
        tick(OSW_LAT);
        checks++; if (o_sw !== 4'b0000) begin failures++; $display("FAIL acc_osw_low got=%b exp=0000", o_sw); end
        tick(4);
    endtask

    task automatic test_glitch;
        bit seen = 1'b0;
        i_sw = 4'b0010;
        tick(3);
        i_sw = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (o_sw != 4'b0000 || o_rise != 4'b0000 || o_changed != 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL glitch_leak osw=%b rise=%b", o_sw, o_rise); end
        // Bounce 1,0,1 then hold: count restarts at the last transition.
        i_sw = 4'b0010;
        tick(2);
        i_sw = 4'b0000;
        tick(2);
        i_sw = 4'b0010;
        tick(5);
        checks++; if (o_rise !== 4'b0000 || o_sw !== 4'b0000) begin failures++; $display("FAIL bounce_early rise=%b osw=%b exp=0000", o_rise, o_sw); end
        tick(1);
        checks++; if (o_rise !== 4'b0010) begin failures++; $display("FAIL bounce_rise got=%b exp=0010", o_rise); end
        tick(OSW_LAT);
        checks++; if (o_sw !== 4'b0010) begin failures++; $display("FAIL bounce_osw got=%b exp=0010", o_sw); end
        i_sw = 4'b0000;
        tick(10);
    endtask

    task automatic test_simultaneous;
        i_sw = 4'b1010;
        tick(5);
        checks++; if (o_rise !== 4'b0000) begin failures++; $display("FAIL sim_early_rise got=%b exp=0000", o_rise); end
        tick(1);
        checks++; if (o_rise !== 4'b1010 || o_changed !== 1'b1) begin failures++; $display("FAIL sim_rise rise=%b chg=%b exp=1010/1", o_rise, o_changed); end
        tick(OSW_LAT);
        // Two bits set: the one-hot stage holds its previous all-zero value.
        checks++; if (o_sw !== ((OSW_LAT != 0) ? 4'b0000 : 4'b1010)) begin failures++; $display("FAIL sim_osw got=%b", o_sw); end
        i_sw = 4'b0000;
        tick(10);
    endtask

    task automatic test_reset_midcount;
        i_sw = 4'b0100;
        tick(3);
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_sw !== 4'b0000) begin failures++; $display("FAIL mid_rst_osw got=%b exp=0000", o_sw); end
        tick(1);
        i_rst_n = 1'b1;
        tick(5);
        checks++; if (o_sw !== 4'b0000 || o_rise !== 4'b0000) begin failures++; $display("FAIL mid_early osw=%b rise=%b exp=0000", o_sw, o_rise); end
        tick(1);
        checks++; if (o_rise !== 4'b0100) begin failures++; $display("FAIL mid_rise got=%b exp=0100", o_rise); end
        tick(OSW_LAT);
        checks++; if (o_sw !== 4'b0100) begin failures++; $display("FAIL mid_osw got=%b exp=0100", o_sw); end
        i_sw = 4'b0000;
        tick(10);
    endtask

`ifdef SW_DEBOUNCE_ONEHOT_EN
    task automatic test_onehot;
        i_sw = 4'b0001;
        tick(8);
        checks++; if (o_sw !== 4'b0001) begin failures++; $display("FAIL oh_first got=%b exp=0001", o_sw); end
        i_sw = 4'b0101;
        tick(6);
        checks++; if (o_rise !== 4'b0100) begin failures++; $display("FAIL oh_rise got=%b exp=0100", o_rise); end
        tick(1);
        checks++; if (o_sw !== 4'b0001) begin failures++; $display("FAIL oh_hold got=%b exp=0001", o_sw); end
        i_sw = 4'b0100;
        tick(6);
        checks++; if (o_fall !== 4'b0001 || o_sw !== 4'b0001) begin failures++; $display("FAIL oh_fall fall=%b osw=%b exp=0001/0001", o_fall, o_sw); end
        tick(1);
        checks++; if (o_sw !== 4'b0100) begin failures++; $display("FAIL oh_switch got=%b exp=0100", o_sw); end
        i_sw = 4'b0000;
        tick(10);
    endtask
`else
    task automatic test_multi_passthrough;
        i_sw = 4'b0001;
        tick(8);
        i_sw = 4'b0101;
        tick(6);
        checks++; if (o_sw !== 4'b0101 || o_rise !== 4'b0100) begin failures++; $display("FAIL multi osw=%b rise=%b exp=0101/0100", o_sw, o_rise); end
        i_sw = 4'b0000;
        tick(10);
    endtask
`endif

    initial begin
        i_rst_n = 1'b1;
        i_sw    = 4'b0000;
        #3 i_rst_n = 1'b0;
        test_reset();
        test_accept();
        test_glitch();
        test_simultaneous();
        test_reset_midcount();
`ifdef SW_DEBOUNCE_ONEHOT_EN
        test_onehot();
`else
        test_multi_passthrough();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
